// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: frame geometry, register map and FSM states for the SPI register controller
package spi_reg_pkg;
  localparam int FRAME_W = 16;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
  localparam logic [CNT_W-1:0] CNT_SAT = 5'd17;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY = 7'h04;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_e;
endpackage

// File: rtl/spi_reg_ctrl_sync_edge.sv
// sync_edge: multi-flop synchronizer for one async input with rise/fall detection
//   clk, rst_n : system clock, synchronous active-low reset
//   d_i        : raw asynchronous input
//   sync_o     : synchronized level
//   rise_o     : one-cycle pulse on a synchronized 0->1 transition
//   fall_o     : one-cycle pulse on a synchronized 1->0 transition
module sync_edge #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic dly_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q <= sync_q[STAGES-1];
    end
  end
  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[STAGES-1] & dly_q;
endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI mode-0 write-only peripheral committing 16-bit frames into five PWM config registers
//   clk, rst_n       : system clock, synchronous active-low reset
//   sclk, copi, ncs  : raw SPI pins, asynchronous to clk
//   en_reg_*         : output/PWM enable registers (addr 0x00..0x03)
//   pwm_duty_cycle   : duty register (addr 0x04)
//   wr_strobe        : one-cycle pulse with the cycle a register takes its new value
//   frame_err        : one-cycle pulse when a frame ends with a bit count other than 16
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 7'h04
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic copi,
  input  logic ncs,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic wr_strobe,
  output logic frame_err
);
  logic sclk_s, sclk_rise, sclk_fall_unused;
  logic ncs_s, ncs_rise, ncs_fall;
  logic copi_s, copi_rise_unused, copi_fall_unused;
  state_e state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] settle_q;
  logic armed_q;
  logic [DATA_W-1:0] out_lo_q, out_lo_d, out_hi_q, out_hi_d;
  logic [DATA_W-1:0] pwm_lo_q, pwm_lo_d, pwm_hi_q, pwm_hi_d;
  logic [DATA_W-1:0] duty_q, duty_d;
  logic wr_q, wr_d, err_q, err_d;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk),
    .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk(clk), .rst_n(rst_n), .d_i(ncs),
    .sync_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
    .clk(clk), .rst_n(rst_n), .d_i(copi),
    .sync_o(copi_s), .rise_o(copi_rise_unused), .fall_o(copi_fall_unused)
  );
  assign addr = sr_q[FRAME_W-2 -: ADDR_W];
  assign data = sr_q[DATA_W-1:0];
  // The ncs synchronizer resets to "deselected", so a pin already low at reset
  // release would look like a falling edge. A frame may only start once a real
  // (post-reset) high level on ncs has been seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_q <= '0;
      armed_q <= 1'b0;
    end else begin
      settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      armed_q <= armed_q | (settle_q[SYNC_STAGES-1] & ncs_s);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      out_lo_q <= '0;
      out_hi_q <= '0;
      pwm_lo_q <= '0;
      pwm_hi_q <= '0;
      duty_q <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      out_lo_q <= out_lo_d;
      out_hi_q <= out_hi_d;
      pwm_lo_q <= pwm_lo_d;
      pwm_hi_q <= pwm_hi_d;
      duty_q <= duty_d;
      wr_q <= wr_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    wr_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ncs_fall && armed_q) begin
          state_d = ST_SHIFT;
          sr_d = '0;
          cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          sr_d = {sr_q[FRAME_W-2:0], copi_s};
          cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 5'd1;
        end
        if (ncs_rise) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        wr_d = (cnt_q == CNT_FULL) && sr_q[FRAME_W-1] && (addr <= MAX_ADDR);
        err_d = cnt_q != CNT_FULL;
      end
      default: state_d = ST_IDLE;
    endcase
    out_lo_d = (wr_d && addr == ADDR_EN_OUT_LO) ? data : out_lo_q;
    out_hi_d = (wr_d && addr == ADDR_EN_OUT_HI) ? data : out_hi_q;
    pwm_lo_d = (wr_d && addr == ADDR_EN_PWM_LO) ? data : pwm_lo_q;
    pwm_hi_d = (wr_d && addr == ADDR_EN_PWM_HI) ? data : pwm_hi_q;
    duty_d = (wr_d && addr == ADDR_PWM_DUTY) ? data : duty_q;
  end
  assign en_reg_out_7_0 = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0 = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle = duty_q;
  assign wr_strobe = wr_q;
  assign frame_err = err_q;
endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

SPI-peripheral register controller for the onboarding PWM design: receives 16-bit write frames from an external SPI controller (mode 0) and commits them into the five configuration registers that enable and drive the PWM/output datapath. Sits inside the top-level user project between the raw `ui_in` pins (SCLK/COPI/nCS) and the PWM generator, which consumes its register outputs directly.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer flops per raw SPI input (≥2).
- `MAX_ADDR`, 7'h04: highest valid register address.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sclk`  in  1  raw SPI clock (async to `clk`), from `ui_in[0]`.
- `copi`  in  1  raw SPI data in, from `ui_in[1]`.
- `ncs`  in  1  raw SPI chip select, active-low, from `ui_in[2]`.
- `en_reg_out_7_0`  out  8  addr 0x00.
- `en_reg_out_15_8`  out  8  addr 0x01.
- `en_reg_pwm_7_0`  out  8  addr 0x02.
- `en_reg_pwm_15_8`  out  8  addr 0x03.
- `pwm_duty_cycle`  out  8  addr 0x04.
- `wr_strobe`  out  1  one-cycle pulse when a register is written.
- `frame_err`  out  1  one-cycle pulse when a frame ends with bit count ≠ 16.

## Operation
- Frame: 16 bits, MSB first, sampled on SCLK rising edge. Bit 15 = R/W (1 = write), bits 14:8 = address, bits 7:0 = data.
- All three raw inputs pass through `SYNC_STAGES` flops; one extra flop per SCLK/nCS gives edge detection (`sclk_rise`, `ncs_fall`, `ncs_rise`).
- FSM states:
  - IDLE: `ncs_fall` → SHIFT; shift register and bit counter cleared.
  - SHIFT: on `sclk_rise`, shift synchronized COPI in at LSB, counter +1, saturating at 17. `ncs_rise` → COMMIT.
  - COMMIT: one cycle, then always → IDLE.
- COMMIT decision:
  - count==16, bit15=1, addr ≤ `MAX_ADDR` → write data to the addressed register, pulse `wr_strobe`.
  - count==16, bit15=0 (read) or addr > `MAX_ADDR` → discard silently, no strobe, no error.
  - count ≠ 16 (short or >16 edges) → discard, pulse `frame_err`.
- SCLK edges while nCS is high are ignored.
- Reset: all five registers 0x00, `wr_strobe`=0, `frame_err`=0, FSM IDLE, counter 0. Sync flops reset to nCS=1, SCLK=0, COPI=0.
- Reset released while nCS is low: the frame is ignored; SHIFT is entered only from a fresh `ncs_fall`.
- Reset asserted mid-frame: frame dropped, no register change.

## Timing
- Registers and `wr_strobe` update on the (`SYNC_STAGES`+2)-th `clk` edge after the first edge that samples raw nCS high (4 with default). `wr_strobe` is high in the same cycle the new value first appears.
- `frame_err` uses identical timing.
- SCLK high and low phases must each be ≥ `SYNC_STAGES`+1 `clk` cycles; COPI must be stable across the SCLK rising edge for the same window.
- nCS high time between frames must be ≥ `SYNC_STAGES`+2 cycles. nCS falling to first SCLK rise must be ≥ `SYNC_STAGES`+1 cycles.
- Register outputs are held constant except in the single COMMIT cycle; no glitches toward the PWM datapath.

## Structure
- Package `spi_reg_pkg`: `FRAME_W`=16, `ADDR_W`=7, the address constants `ADDR_EN_OUT_LO`/`_HI`, `ADDR_EN_PWM_LO`/`_HI` and `ADDR_PWM_DUTY`, and the FSM state enum.
- Sub-module `sync_edge`: parameterized synchronizer plus rise/fall detect with a reset value parameter; instantiated for sclk and ncs, and for copi using the sync output only.
- The top-level user project instantiates `spi_reg_ctrl` and feeds its registers to the PWM block.

## Test plan
- Reset, then write frame 0x8055 (addr 0x00, data 0x55) → `en_reg_out_7_0`=0x55 with one `wr_strobe` pulse 4 cycles after nCS rises; other registers stay 0x00.
- Writes 0x81F0, 0x82AA, 0x830F, 0x8480 → registers 0x01..0x04 = F0, AA, 0F, 80; exactly 5 strobes in total.
- Read frame 0x0433, then write to addr 0x05 (0x8599) → no register change, no strobe, no `frame_err`.
- 12-bit frame, then 18-bit frame → each produces one `frame_err` pulse; registers unchanged; a following valid 0x84C0 sets duty to 0xC0.
- Assert `rst_n` low after 8 bits of 0x8412 with registers preloaded → all registers 0x00; release with nCS still low and finish the frame → no write; next full frame is accepted.
- SCLK toggling with nCS high, then a valid 0x8001 → only addr 0x00=0x01 written.
